// File: rtl/div_datapath_pkg.sv
// Shared widths and the two's-complement helpers used by the division datapath.
package div_datapath_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = 32;

  typedef logic [DIV_WIDTH-1:0] word_t;

  function automatic word_t negate(input word_t x);
    return ~x + word_t'(1);
  endfunction

  // Magnitude as unsigned, so abs(0x80000000) stays 0x80000000.
  function automatic word_t abs(input word_t x);
    return x[DIV_WIDTH-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/div_datapath_if.sv
// Operand, div_ctrl handshake and result signals of the division datapath.
interface div_datapath_if;
  import div_datapath_pkg::*;

  logic  ctrl_div;
  word_t dividend;
  word_t divisor;
  logic  first_cycle;
  logic  data_res_rdy;
  word_t chosen_add;
  word_t pos_divisor;
  logic  div_select;
  word_t quotient;
  logic  data_exception;
  logic  data_result_rdy;
  logic  busy;

  modport master (
    output ctrl_div, dividend, divisor, first_cycle, data_res_rdy, chosen_add,
    input  pos_divisor, div_select, quotient, data_exception, data_result_rdy, busy
  );

  modport slave (
    input  ctrl_div, dividend, divisor, first_cycle, data_res_rdy, chosen_add,
    output pos_divisor, div_select, quotient, data_exception, data_result_rdy, busy
  );

endinterface

// File: rtl/div_datapath_negate32.sv
// Conditional two's-complement negator: y = en ? -a : a.
module negate32
  import div_datapath_pkg::*;
(
  input  word_t a,
  input  logic  en,
  output word_t y
);

  assign y = en ? negate(a) : a;

endmodule

// File: rtl/div_datapath.sv
// Non-restoring signed divider datapath driven by div_ctrl's count-derived flags.
module div_datapath
  import div_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic           clk,
  input logic           reset,
  div_datapath_if.slave bus
);

  logic [WIDTH:0]   a_q, a_d, a_iter;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] pos_divisor_q, pos_divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic             sn_q, sn_d, sd_q, sd_d, z_q, z_d;
  logic             busy_q, busy_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             div_select;
  word_t            abs_dividend, abs_divisor, q_signed;

  negate32 u_abs_dividend (
    .a  (bus.dividend),
    .en (bus.dividend[WIDTH-1]),
    .y  (abs_dividend)
  );

  negate32 u_abs_divisor (
    .a  (bus.divisor),
    .en (bus.divisor[WIDTH-1]),
    .y  (abs_divisor)
  );

  negate32 u_sign_fix (
    .a  (q_q),
    .en (sn_q ^ sd_q),
    .y  (q_signed)
  );

  assign div_select = ~a_q[WIDTH];

  // Top bit of the addend tracks div_select so that -2^31 sign-extends correctly.
  assign a_iter = {a_q[WIDTH-1:0], q_q[WIDTH-1]} + {div_select, bus.chosen_add};

  always_comb begin
    a_d           = a_q;
    q_d           = q_q;
    pos_divisor_d = pos_divisor_q;
    quotient_d    = quotient_q;
    sn_d          = sn_q;
    sd_d          = sd_q;
    z_d           = z_q;
    busy_d        = busy_q;
    exc_d         = exc_q;
    rdy_d         = 1'b0;
    if (bus.ctrl_div) begin
      a_d           = '0;
      q_d           = abs_dividend;
      pos_divisor_d = abs_divisor;
      sn_d          = bus.dividend[WIDTH-1];
      sd_d          = bus.divisor[WIDTH-1];
      z_d           = (bus.divisor == '0);
      busy_d        = 1'b1;
      exc_d         = 1'b0;
    end else if (busy_q && bus.data_res_rdy) begin
      quotient_d = z_q ? '0 : q_signed;
      exc_d      = z_q;
      rdy_d      = 1'b1;
      busy_d     = 1'b0;
    end else if (busy_q) begin
      a_d = a_iter;
      q_d = {q_q[WIDTH-2:0], ~a_iter[WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q           <= '0;
      q_q           <= '0;
      pos_divisor_q <= '0;
      quotient_q    <= '0;
      sn_q          <= 1'b0;
      sd_q          <= 1'b0;
      z_q           <= 1'b0;
      busy_q        <= 1'b0;
      exc_q         <= 1'b0;
      rdy_q         <= 1'b0;
    end else begin
      a_q           <= a_d;
      q_q           <= q_d;
      pos_divisor_q <= pos_divisor_d;
      quotient_q    <= quotient_d;
      sn_q          <= sn_d;
      sd_q          <= sd_d;
      z_q           <= z_d;
      busy_q        <= busy_d;
      exc_q         <= exc_d;
      rdy_q         <= rdy_d;
    end
  end

  assign bus.pos_divisor     = pos_divisor_q;
  assign bus.div_select      = div_select;
  assign bus.quotient        = quotient_q;
  assign bus.data_exception  = exc_q;
  assign bus.data_result_rdy = rdy_q;
  assign bus.busy            = busy_q;

  // The first iteration must see the remainder freshly cleared by the start edge.
  first_iter_aligned : assert property (@(posedge clk) disable iff (!reset)
    (busy_q && bus.first_cycle && !bus.ctrl_div) |-> (a_q == '0));

endmodule

// File: tb/tb_div_datapath.sv
// Directed-vector bench for div_datapath with a behavioural div_ctrl counter.
module tb_div_datapath;
  import div_datapath_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [5:0] cnt;

  div_datapath_if dif ();

  div_datapath #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  // div_ctrl stand-in: counter cleared by the start pulse, free-running otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (dif.ctrl_div) cnt <= '0;
    else                   cnt <= cnt + 6'd1;
  end

  assign dif.first_cycle  = (cnt == 6'd0);
  assign dif.data_res_rdy = (cnt == 6'd32);
  assign dif.chosen_add   = dif.div_select ? (32'd0 - dif.pos_divisor) : dif.pos_divisor;

  // Returns at the falling edge just after the start edge E0.
  task automatic start_op(input word_t n, input word_t d);
    @(negedge clk);
    dif.ctrl_div = 1'b1;
    dif.dividend = n;
    dif.divisor  = d;
    @(posedge clk);
    @(negedge clk);
    dif.ctrl_div = 1'b0;
  endtask

  task automatic finish_op(output int early, output logic rdy_at, output word_t q,
                           output logic exc, output logic busy_at, output logic rdy_after);
    early = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (dif.data_result_rdy) early++;
    end
    @(negedge clk);
    rdy_at  = dif.data_result_rdy;
    q       = dif.quotient;
    exc     = dif.data_exception;
    busy_at = dif.busy;
    @(negedge clk);
    rdy_after = dif.data_result_rdy;
  endtask

  task automatic test_reset;
    dif.ctrl_div = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    rst_n = 1'b0;
    #12;
    n_vec++; if (dif.quotient !== 32'd0) begin n_err++; $display("FAIL reset_quotient got %h want 0", dif.quotient); end
    n_vec++; if (dif.data_exception !== 1'b0) begin n_err++; $display("FAIL reset_exc got %b want 0", dif.data_exception); end
    n_vec++; if (dif.data_result_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %b want 0", dif.data_result_rdy); end
    n_vec++; if (dif.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", dif.busy); end
    n_vec++; if (dif.pos_divisor !== 32'd0) begin n_err++; $display("FAIL reset_posd got %h want 0", dif.pos_divisor); end
    n_vec++; if (dif.div_select !== 1'b1) begin n_err++; $display("FAIL reset_select got %b want 1", dif.div_select); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int early; logic rdy_at, exc, busy_at, rdy_after; word_t q;
    start_op(32'd100, 32'd7);
    n_vec++; if (dif.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b want 1", dif.busy); end
    n_vec++; if (dif.pos_divisor !== 32'd7) begin n_err++; $display("FAIL basic_posd got %h want 7", dif.pos_divisor); end
    finish_op(early, rdy_at, q, exc, busy_at, rdy_after);
    n_vec++; if (early !== 0) begin n_err++; $display("FAIL basic_early got %0d want 0", early); end
    n_vec++; if (rdy_at !== 1'b1) begin n_err++; $display("FAIL basic_rdy_e33 got %b want 1", rdy_at); end
    n_vec++; if (q !== 32'd14) begin n_err++; $display("FAIL basic_quot got %h want 0000000e", q); end
    n_vec++; if (exc !== 1'b0) begin n_err++; $display("FAIL basic_exc got %b want 0", exc); end
    n_vec++; if (busy_at !== 1'b0) begin n_err++; $display("FAIL basic_busy_done got %b want 0", busy_at); end
    n_vec++; if (rdy_after !== 1'b0) begin n_err++; $display("FAIL basic_rdy_e34 got %b want 0", rdy_after); end
  endtask

  task automatic test_signs;
    word_t vn[3] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C};
    word_t vd[3] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    word_t vq[3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
    int early; logic rdy_at, exc, busy_at, rdy_after; word_t q;
    for (int i = 0; i < 3; i++) begin
      start_op(vn[i], vd[i]);
      finish_op(early, rdy_at, q, exc, busy_at, rdy_after);
      n_vec++; if (rdy_at !== 1'b1 || early !== 0) begin n_err++; $display("FAIL signs_rdy[%0d] got %b/%0d want 1/0", i, rdy_at, early); end
      n_vec++; if (q !== vq[i]) begin n_err++; $display("FAIL signs_quot[%0d] got %h want %h", i, q, vq[i]); end
    end
  endtask

  task automatic test_div_zero;
    int early; logic rdy_at, exc, busy_at, rdy_after; word_t q;
    start_op(32'd7, 32'd0);
    finish_op(early, rdy_at, q, exc, busy_at, rdy_after);
    n_vec++; if (q !== 32'd0) begin n_err++; $display("FAIL dz_quot got %h want 0", q); end
    n_vec++; if (exc !== 1'b1) begin n_err++; $display("FAIL dz_exc got %b want 1", exc); end
    n_vec++; if (rdy_at !== 1'b1 || rdy_after !== 1'b0 || early !== 0) begin
      n_err++; $display("FAIL dz_pulse got %b%b/%0d want 10/0", rdy_at, rdy_after, early);
    end
    start_op(32'd9, 32'd3);
    n_vec++; if (dif.data_exception !== 1'b0) begin n_err++; $display("FAIL dz_exc_clear got %b want 0", dif.data_exception); end
    n_vec++; if (dif.quotient !== 32'd0) begin n_err++; $display("FAIL dz_quot_hold got %h want 0", dif.quotient); end
    finish_op(early, rdy_at, q, exc, busy_at, rdy_after);
    n_vec++; if (q !== 32'd3) begin n_err++; $display("FAIL dz_next_quot got %h want 3", q); end
  endtask

  task automatic test_boundary;
    int early; logic rdy_at, exc, busy_at, rdy_after; word_t q;
    start_op(32'h80000000, 32'hFFFFFFFF);
    finish_op(early, rdy_at, q, exc, busy_at, rdy_after);
    n_vec++; if (q !== 32'h80000000) begin n_err++; $display("FAIL ovf_quot got %h want 80000000", q); end
    n_vec++; if (exc !== 1'b0) begin n_err++; $display("FAIL ovf_exc got %b want 0", exc); end
    start_op(32'd5, 32'h80000000);
    n_vec++; if (dif.pos_divisor !== 32'h80000000) begin n_err++; $display("FAIL min_posd got %h want 80000000", dif.pos_divisor); end
    finish_op(early, rdy_at, q, exc, busy_at, rdy_after);
    n_vec++; if (q !== 32'd0) begin n_err++; $display("FAIL min_quot got %h want 0", q); end
  endtask

  task automatic test_restart;
    int early; logic rdy_at, exc, busy_at, rdy_after; word_t q;
    start_op(32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    start_op(32'd50, 32'd5);  // start edge lands on E10 of the first op
    finish_op(early, rdy_at, q, exc, busy_at, rdy_after);
    n_vec++; if (early !== 0 || rdy_at !== 1'b1 || rdy_after !== 1'b0) begin
      n_err++; $display("FAIL restart_pulse got %0d/%b%b want 0/10", early, rdy_at, rdy_after);
    end
    n_vec++; if (q !== 32'd10) begin n_err++; $display("FAIL restart_quot got %h want 0000000a", q); end
  endtask

  task automatic test_collision;
    int early; logic rdy_at, exc, busy_at, rdy_after; word_t q;
    start_op(32'd20, 32'd4);
    repeat (31) @(negedge clk);
    start_op(32'd77, 32'd7);  // start edge coincides with the result edge E33
    n_vec++; if (dif.data_result_rdy !== 1'b0) begin n_err++; $display("FAIL coll_no_pulse got %b want 0", dif.data_result_rdy); end
    n_vec++; if (dif.quotient !== 32'd10) begin n_err++; $display("FAIL coll_quot_hold got %h want 0000000a", dif.quotient); end
    finish_op(early, rdy_at, q, exc, busy_at, rdy_after);
    n_vec++; if (early !== 0 || rdy_at !== 1'b1) begin n_err++; $display("FAIL coll_pulse got %0d/%b want 0/1", early, rdy_at); end
    n_vec++; if (q !== 32'd11) begin n_err++; $display("FAIL coll_quot got %h want 0000000b", q); end
  endtask

  task automatic test_reset_mid;
    int early, pulses; logic rdy_at, exc, busy_at, rdy_after; word_t q;
    start_op(32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if (dif.busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", dif.busy); end
    n_vec++; if (dif.quotient !== 32'd0) begin n_err++; $display("FAIL rmid_quot got %h want 0", dif.quotient); end
    n_vec++; if (dif.pos_divisor !== 32'd0 || dif.div_select !== 1'b1) begin
      n_err++; $display("FAIL rmid_posd_sel got %h/%b want 0/1", dif.pos_divisor, dif.div_select);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dif.data_result_rdy) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rmid_no_pulse got %0d want 0", pulses); end
    start_op(32'd9, 32'd3);
    finish_op(early, rdy_at, q, exc, busy_at, rdy_after);
    n_vec++; if (q !== 32'd3 || rdy_at !== 1'b1) begin n_err++; $display("FAIL rmid_next got %h/%b want 3/1", q, rdy_at); end
    // Counter wraps through first_cycle and count=32 while idle.
    pulses = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (dif.data_result_rdy) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL idle_no_pulse got %0d want 0", pulses); end
    n_vec++; if (dif.quotient !== 32'd3 || dif.data_exception !== 1'b0) begin
      n_err++; $display("FAIL idle_hold got %h/%b want 3/0", dif.quotient, dif.data_exception);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_boundary();
    test_restart();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_datapath.md
# div_datapath

Iterative signed-division datapath sitting directly downstream of the divider control block (`div_ctrl`). It latches operands on a start pulse and produces the magnitude divisor that `div_ctrl` selects from. It consumes `div_ctrl`'s add/subtract value and phase flags to run 32 non-restoring iterations. It then applies sign correction and flags divide-by-zero, presenting a registered quotient with a one-cycle ready pulse to the multdiv result path.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported, matching `div_ctrl`'s 6-bit counter.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ctrl_div`  in  1  start pulse; operands are sampled on the same edge. The parent also uses it to clear `div_ctrl`'s counter.
- `dividend`  in  32  signed dividend, valid when `ctrl_div`=1.
- `divisor`  in  32  signed divisor, valid when `ctrl_div`=1.
- `first_cycle`  in  1  from `div_ctrl`; high while count=0.
- `data_res_rdy`  in  1  from `div_ctrl`; high while count=32.
- `chosen_add`  in  32  from `div_ctrl`; equals `pos_divisor` when `div_select`=0, and `-pos_divisor` when `div_select`=1.
- `pos_divisor`  out  32  registered |divisor| as unsigned.
- `div_select`  out  1  combinational; `~A[32]`, i.e. 1 requests a subtract.
- `quotient`  out  32  registered signed quotient.
- `data_exception`  out  1  registered; set when divisor==0.
- `data_result_rdy`  out  1  registered one-cycle pulse.
- `busy`  out  1  high from the cycle after `ctrl_div` until the result edge.

## Operation
- State consists of:
  - a 33-bit partial remainder A;
  - a 32-bit quotient shift register Q;
  - latched sign bits sN and sD;
  - a zero-divisor flag z;
  - `busy`.
- On an edge with `ctrl_div`=1, the block latches:
  - A=0;
  - Q=|dividend|;
  - `pos_divisor`=|divisor|;
  - sN and sD;
  - z=(divisor==0);
  - `busy`=1.
- `ctrl_div` takes priority over everything else and restarts any operation in progress.
- On an edge with `busy`=1, `data_res_rdy`=0, and no `ctrl_div`, the block performs one iteration:
  - {A,Q} is shifted left by one;
  - A is replaced by A_shifted + {`div_select`, `chosen_add`}, where the sign-extension bit equals `div_select` so that |divisor|=2^31 is handled correctly;
  - Q[0] is set to ~A_new[32].
- `first_cycle` is an iteration cycle; it only cross-checks that the count is aligned.
- On an edge with `busy`=1 and `data_res_rdy`=1:
  - `quotient` = (sN^sD) ? -Q : Q, or 0 if z;
  - `data_exception`=z;
  - `data_result_rdy` pulses to 1;
  - `busy` clears.
- When `busy`=0, all `div_ctrl` inputs are ignored. The `div_ctrl` counter free-runs past 32 and must have no effect.
- The remainder is not restored and is not output.
- Arithmetic rules:
  - |x| is the two's-complement negation taken as unsigned, so |0x80000000| = 0x80000000.
  - 0x80000000 / -1 wraps to 0x80000000 with `data_exception`=0.
  - Signs are truncating (C semantics).
- `quotient` and `data_exception` hold their values until the next result edge.
- `data_exception` is cleared on the next `ctrl_div`.

## Timing
- ctrl_div latch edge E0.
- count=0 runs E0–E1.
- Iterations happen at E1..E32, which is 32 iterations.
- count=32 spans E32–E33.
- The result registers at E33.
- `data_result_rdy`=1 during E33–E34.
- Total latency is 33 edges from start to result.
- Reset values:
  - A=0, so `div_select`=1;
  - Q=0;
  - `pos_divisor`=0;
  - `quotient`=0;
  - `data_exception`=0;
  - `data_result_rdy`=0;
  - `busy`=0.
- Asserting reset mid-operation aborts it immediately; no result pulse follows.
- If `ctrl_div` arrives on the same edge as the result edge, the start wins and no pulse is generated.
- `ctrl_div` during an iteration restarts the operation; the new result arrives 33 edges later.

## Structure
- Shared package:
  - `DIV_WIDTH`=32;
  - `DIV_ITERS`=32;
  - the `abs`/`negate` function signature.
- One natural sub-module, `negate32`: a two's-complement negator reused for |dividend|, |divisor| and sign correction.
- Registers, iteration logic and result capture stay in `div_datapath`.

## Test plan
- 100 / 7 -> `quotient`=14, `data_exception`=0, `data_result_rdy` high exactly at E33.
- -100 / 7 -> `quotient`=-14 (0xFFFFFFF2); 100 / -7 -> -14; -100 / -7 -> 14.
- 7 / 0 -> `quotient`=0, `data_exception`=1, single-cycle ready pulse.
- 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 0. Separately, 5 / 0x80000000 -> 0.
- Start 1000/3, re-pulse `ctrl_div` with 50/5 at E10 -> exactly one `data_result_rdy`, 33 edges after the second start, with `quotient`=10.
- Assert reset at E15 of 1000/3 -> all outputs return to their reset values and no ready pulse occurs; a following 9/3 then yields 3.
